// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: latches the decode bus, runs the ALU,
// issues the data-SRAM request and forwards results to memory and back to decode.
module exe_stage #(
  parameter int unsigned DS_TO_ES_BUS_WD = 136,
  parameter int unsigned ES_TO_MS_BUS_WD = 71,
  parameter int unsigned ES_FWD_BUS_WD   = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  localparam int unsigned ALU_OP_WD = 12;
  localparam int unsigned DATA_WD   = 32;
  localparam int unsigned REG_WD    = 5;
  localparam int unsigned IMM_WD    = 16;
  localparam int unsigned SHAMT_WD  = 5;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_sa;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_8;
    logic                 gr_we;
    logic                 mem_we;
    logic [REG_WD-1:0]    dest;
    logic [IMM_WD-1:0]    imm;
    logic [DATA_WD-1:0]   rs_value;
    logic [DATA_WD-1:0]   rt_value;
    logic [DATA_WD-1:0]   pc;
  } ds_bus_t;

  typedef struct packed {
    logic               res_from_mem;
    logic               gr_we;
    logic [REG_WD-1:0]  dest;
    logic [DATA_WD-1:0] alu_result;
    logic [DATA_WD-1:0] pc;
  } ms_bus_t;

  typedef struct packed {
    logic               fwd_we;
    logic               fwd_is_load;
    logic [REG_WD-1:0]  fwd_dest;
    logic [DATA_WD-1:0] alu_result;
  } fwd_bus_t;

  logic               es_valid;
  logic               es_ready_go;
  logic               es_fire;
  ds_bus_t            es_bus_r;
  logic [DATA_WD-1:0] src1;
  logic [DATA_WD-1:0] src2;
  logic [DATA_WD-1:0] alu_result;
  ms_bus_t            ms_bus;
  fwd_bus_t           fwd_bus;

  // Handshake: single-cycle stage, stalls only on downstream back-pressure
  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  // Bus register holds across stalls and bubbles so a stalled instruction stays intact
  always_ff @(posedge clk) begin
    if (reset) begin
      es_bus_r <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      es_bus_r <= ds_to_es_bus;
    end
  end

  // Operand selection
  always_comb begin
    src1 = es_bus_r.rs_value;
    src2 = es_bus_r.rt_value;
    if (es_bus_r.src1_is_sa) begin
      src1 = {(DATA_WD-SHAMT_WD)'(0), es_bus_r.imm[10:6]};
    end else if (es_bus_r.src1_is_pc) begin
      src1 = es_bus_r.pc;
    end
    if (es_bus_r.src2_is_imm) begin
      src2 = {{(DATA_WD-IMM_WD){es_bus_r.imm[IMM_WD-1]}}, es_bus_r.imm};
    end else if (es_bus_r.src2_is_8) begin
      src2 = DATA_WD'(8);
    end
  end

  // ALU: one-hot op select; an all-zero op vector yields zero
  logic [DATA_WD-1:0] add_res, sub_res, slt_res, sltu_res;
  logic [DATA_WD-1:0] and_res, nor_res, or_res, xor_res;
  logic [DATA_WD-1:0] sll_res, srl_res, sra_res, lui_res;
  logic [SHAMT_WD-1:0] shamt;

  assign shamt    = src1[SHAMT_WD-1:0];
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {(DATA_WD-1)'(0), ($signed(src1) < $signed(src2))};
  assign sltu_res = {(DATA_WD-1)'(0), (src1 < src2)};
  assign and_res  = src1 & src2;
  assign nor_res  = ~(src1 | src2);
  assign or_res   = src1 | src2;
  assign xor_res  = src1 ^ src2;
  assign sll_res  = src2 << shamt;
  assign srl_res  = src2 >> shamt;
  assign sra_res  = DATA_WD'($signed(src2) >>> shamt);
  assign lui_res  = {src2[IMM_WD-1:0], IMM_WD'(0)};

  always_comb begin
    alu_result = ({DATA_WD{es_bus_r.alu_op[0]}}  & add_res)
               | ({DATA_WD{es_bus_r.alu_op[1]}}  & sub_res)
               | ({DATA_WD{es_bus_r.alu_op[2]}}  & slt_res)
               | ({DATA_WD{es_bus_r.alu_op[3]}}  & sltu_res)
               | ({DATA_WD{es_bus_r.alu_op[4]}}  & and_res)
               | ({DATA_WD{es_bus_r.alu_op[5]}}  & nor_res)
               | ({DATA_WD{es_bus_r.alu_op[6]}}  & or_res)
               | ({DATA_WD{es_bus_r.alu_op[7]}}  & xor_res)
               | ({DATA_WD{es_bus_r.alu_op[8]}}  & sll_res)
               | ({DATA_WD{es_bus_r.alu_op[9]}}  & srl_res)
               | ({DATA_WD{es_bus_r.alu_op[10]}} & sra_res)
               | ({DATA_WD{es_bus_r.alu_op[11]}} & lui_res);
  end

  // Memory request fires once, on the transfer cycle; reset squashes a pending instruction
  assign es_fire         = es_valid && ms_allowin && !reset;
  assign data_sram_en    = es_fire && (es_bus_r.load_op || es_bus_r.mem_we);
  assign data_sram_wen   = {4{es_fire && es_bus_r.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus_r.rt_value;

  always_comb begin
    ms_bus.res_from_mem = es_bus_r.load_op;
    ms_bus.gr_we        = es_bus_r.gr_we;
    ms_bus.dest         = es_bus_r.dest;
    ms_bus.alu_result   = alu_result;
    ms_bus.pc           = es_bus_r.pc;
  end

  // Forwarding info for decode bypass and load-use stall detection
  always_comb begin
    fwd_bus.fwd_we      = es_valid && es_bus_r.gr_we && (es_bus_r.dest != '0);
    fwd_bus.fwd_is_load = es_valid && es_bus_r.load_op;
    fwd_bus.fwd_dest    = es_bus_r.dest;
    fwd_bus.alu_result  = alu_result;
  end

  assign es_to_ms_bus = ms_bus;
  assign es_fwd_bus   = fwd_bus;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expected results queued on accept, compared on transfer.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [135:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fwd_bus      (es_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [70:0] ms;
    logic [38:0] fwd;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pop_cnt = 0;
  int   wen_cycles = 0;
  int   issue_waits = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] mk(input int op, input logic load, input logic sa,
                                      input logic pcs, input logic immsel, input logic is8,
                                      input logic gwe, input logic mwe, input logic [4:0] dest,
                                      input logic [15:0] imm, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] pc);
    logic [11:0] oh;
    oh = '0;
    if (op >= 0 && op < 12) oh[4'(op)] = 1'b1;
    return {oh, load, sa, pcs, immsel, is8, gwe, mwe, dest, imm, rs, rt, pc};
  endfunction

  // Reference ALU for randomised traffic
  function automatic logic [31:0] alu_ref(input int op, input logic [135:0] b);
    logic [31:0] a, s;
    logic [63:0] ext;
    if (b[122])      a = {27'd0, b[106:102]};
    else if (b[121]) a = b[31:0];
    else             a = b[95:64];
    if (b[120])      s = {{16{b[111]}}, b[111:96]};
    else if (b[119]) s = 32'd8;
    else             s = b[63:32];
    ext = {{32{s[31]}}, s} >> a[4:0];
    case (op)
      0:  return a + s;
      1:  return a + (~s) + 32'd1;
      2:  return ((a[31] & ~s[31]) | ((a[31] == s[31]) & (a < s))) ? 32'd1 : 32'd0;
      3:  return (a < s) ? 32'd1 : 32'd0;
      4:  return a & s;
      5:  return ~(a | s);
      6:  return a | s;
      7:  return a ^ s;
      8:  return s << a[4:0];
      9:  return s >> a[4:0];
      10: return ext[31:0];
      11: return {s[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [135:0] b, input logic [31:0] res);
    exp_t e;
    int   w;
    e.ms    = {b[123], b[118], b[116:112], res, b[31:0]};
    e.fwd   = {b[118] && (b[116:112] != 5'd0), b[123], b[116:112], res};
    e.en    = b[123] | b[117];
    e.wen   = {4{b[117]}};
    e.addr  = res;
    e.wdata = b[63:32];
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    w = 0;
    @(negedge clk);
    while (!es_allowin && w < 20) begin
      w++;
      @(negedge clk);
    end
    issue_waits += w;
    check("accept_allowin", 128'(es_allowin), 128'(1));
    if (es_allowin) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Transfer monitor: every fire pops one expected result
  always @(negedge clk) begin
    if (data_sram_wen != 4'h0) wen_cycles++;
    if (!reset && es_to_ms_valid && ms_allowin) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        pop_cnt++;
        check("ms_bus", 128'(es_to_ms_bus), 128'(e.ms));
        check("fwd_bus", 128'(es_fwd_bus), 128'(e.fwd));
        check("sram_en", 128'(data_sram_en), 128'(e.en));
        check("sram_wen", 128'(data_sram_wen), 128'(e.wen));
        if (e.en) begin
          check("sram_addr", 128'(data_sram_addr), 128'(e.addr));
          check("sram_wdata", 128'(data_sram_wdata), 128'(e.wdata));
        end
      end
    end
  end

  initial begin
    int p0, w0, op;
    logic [135:0] b;
    reset = 1'b1;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 128'(es_to_ms_valid), 128'(0));
    check("rst_en", 128'(data_sram_en), 128'(0));
    check("rst_wen", 128'(data_sram_wen), 128'(0));
    check("rst_fwd_flags", 128'(es_fwd_bus[38:37]), 128'(0));
    check("rst_allowin", 128'(es_allowin), 128'(1));
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed ALU cases issued back to back
    issue(mk(0, 0,0,0,0,0, 1,0, 5'd2, 16'h0, 32'h7FFFFFFF, 32'h1, 32'h0), 32'h80000000);
    issue(mk(2, 0,0,0,0,0, 1,0, 5'd3, 16'h0, 32'hFFFFFFFF, 32'h1, 32'h4), 32'h1);
    issue(mk(3, 0,0,0,0,0, 1,0, 5'd3, 16'h0, 32'hFFFFFFFF, 32'h1, 32'h8), 32'h0);
    issue(mk(10, 0,1,0,0,0, 1,0, 5'd4, 16'h0100, 32'h0, 32'h80000000, 32'hC), 32'hF8000000);
    issue(mk(11, 0,0,0,1,0, 1,0, 5'd4, 16'h1234, 32'h0, 32'h0, 32'h10), 32'h12340000);
    ds_to_es_valid = 1'b0;
    @(posedge clk); #1;

    // Store held off by three stall cycles, then written exactly once
    issue(mk(0, 0,0,0,1,0, 0,1, 5'd0, 16'hFFFC, 32'h100, 32'hDEADBEEF, 32'h20), 32'h000000FC);
    ds_to_es_valid = 1'b0;
    ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wen", 128'(data_sram_wen), 128'(0));
      check("stall_en", 128'(data_sram_en), 128'(0));
      check("stall_valid", 128'(es_to_ms_valid), 128'(1));
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("sw_once", 128'(data_sram_wen), 128'(0));
    @(posedge clk); #1;

    // Load, jal link, and a write to $0
    issue(mk(0, 1,0,0,1,0, 1,0, 5'd5, 16'h0010, 32'h1000, 32'h0, 32'h24), 32'h1010);
    issue(mk(0, 0,0,1,0,1, 1,0, 5'd31, 16'h0, 32'h0, 32'h0, 32'hBFC00010), 32'hBFC00018);
    issue(mk(0, 0,0,0,0,0, 1,0, 5'd0, 16'h0, 32'h3, 32'h4, 32'h28), 32'h7);
    ds_to_es_valid = 1'b0;
    @(posedge clk); #1;

    // Random back-to-back burst: one result per cycle
    p0 = pop_cnt;
    w0 = issue_waits;
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 11));
      b = mk(op, 1'($urandom), ((op >= 8 && op <= 10) ? 1'($urandom) : 1'b0), 1'b0,
             1'($urandom), 1'b0, 1'($urandom), 1'b0, 5'($urandom), 16'($urandom),
             $urandom, $urandom, $urandom);
      issue(b, alu_ref(op, b));
    end
    ds_to_es_valid = 1'b0;
    @(posedge clk); #1;
    check("burst_pops", 128'(pop_cnt - p0), 128'(24));
    check("burst_waits", 128'(issue_waits - w0), 128'(0));

    // Reset while a store is stalled: discarded, no request on reset cycle or after
    issue(mk(0, 0,0,0,1,0, 0,1, 5'd0, 16'h0040, 32'h0, 32'h12345678, 32'h30), 32'h40);
    ds_to_es_valid = 1'b0;
    ms_allowin = 1'b0;
    @(negedge clk);
    check("rst_stall_en", 128'(data_sram_en), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    ms_allowin = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_cycle_en", 128'(data_sram_en), 128'(0));
    check("rst_cycle_wen", 128'(data_sram_wen), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_en", 128'(data_sram_en), 128'(0));
    check("post_rst_valid", 128'(es_to_ms_valid), 128'(0));
    @(posedge clk); #1;

    check("sb_empty", 128'(sb.size()), 128'(0));
    check("store_count", 128'(wen_cycles), 128'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
